// File: rtl/deserializador.sv
// Serial-to-parallel front end for the 8-entry queue: MSB-first bit assembly, push on queue not-full.
// Optional even-parity frame check is enabled by defining PARITY_EN.
module deserializador #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_10KHz,
    input  logic             reset,
    input  logic             data_in,
    input  logic             write_in,
    input  logic             full_in,
    output logic [WIDTH-1:0] data_out,
    output logic             enqueue_out,
    output logic             status_out,
    output logic             parity_err_out
);

    localparam int unsigned CW = $clog2(WIDTH + 2);
`ifdef PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif

    typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    count, count_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] data_n;
    logic             enq_n;
    logic             status_n;
`ifdef PARITY_EN
    logic             par, par_n;
    logic             perr_n;
`endif

    // State and output registers
    always_ff @(posedge clk_10KHz or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            shreg       <= '0;
            data_out    <= '0;
            enqueue_out <= 1'b0;
            status_out  <= 1'b1;
`ifdef PARITY_EN
            par            <= 1'b0;
            parity_err_out <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            count       <= count_n;
            shreg       <= shreg_n;
            data_out    <= data_n;
            enqueue_out <= enq_n;
            status_out  <= status_n;
`ifdef PARITY_EN
            par            <= par_n;
            parity_err_out <= perr_n;
`endif
        end
    end

`ifndef PARITY_EN
    assign parity_err_out = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        count_n  = count;
        shreg_n  = shreg;
        data_n   = data_out;
        enq_n    = 1'b0;
        status_n = status_out;
`ifdef PARITY_EN
        par_n    = par;
        perr_n   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (write_in) begin
                    shreg_n = {shreg[WIDTH-2:0], data_in};
                    count_n = CW'(1);
                    state_n = RECV;
`ifdef PARITY_EN
                    par_n   = data_in;
`endif
                end
            end
            RECV: begin
                if (write_in) begin
                    // The trailing parity bit only feeds the running XOR, never the word
                    if (count < CW'(WIDTH)) begin
                        shreg_n = {shreg[WIDTH-2:0], data_in};
                    end
                    count_n = count + CW'(1);
`ifdef PARITY_EN
                    par_n   = par ^ data_in;
`endif
                    if (count_n == CW'(FRAME)) begin
                        state_n  = HOLD;
                        status_n = 1'b0;
                    end
                end
            end
            HOLD: begin
`ifdef PARITY_EN
                if (par) begin
                    perr_n   = 1'b1;
                    status_n = 1'b1;
                    count_n  = '0;
                    state_n  = IDLE;
                end else
`endif
                if (!full_in) begin
                    data_n   = shreg;
                    enq_n    = 1'b1;
                    status_n = 1'b1;
                    count_n  = '0;
                    state_n  = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                count_n = '0;
            end
        endcase
    end

endmodule
